// File: rtl/set_seq_pkg.sv
// Shared definitions for the set/release sequencer: state encoding,
// phase counter width, and parameter defaults with their legal limits.
package set_seq_pkg;

    localparam int CNT_W = 8;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    localparam int HOLD_CYCLES_DEF = 4;
    localparam int HOLD_CYCLES_MIN = 1;
    localparam int HOLD_CYCLES_MAX = 255;

    localparam int REC_CYCLES_DEF  = 2;
    localparam int REC_CYCLES_MIN  = 1;
    localparam int REC_CYCLES_MAX  = 255;

    typedef enum logic [2:0] {
        ST_RST_SYNC = 3'd0,
        ST_GATE     = 3'd1,
        ST_ASSERT   = 3'd2,
        ST_RECOVER  = 3'd3,
        ST_IDLE     = 3'd4
    } state_t;

    // Counter value loaded on entry to a state lasting len cycles.
    function automatic logic [CNT_W-1:0] cnt_load(input int len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/set_seq_rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES
// rising clock edges so downstream logic sees a clean deassertion.
module set_seq_rst_sync
    import set_seq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/set_release_sequencer.sv
// Sequences the active-low set of a negative-edge flop bank: stop the bank
// clock, pulse SETN low, wait a recovery gap, then re-enable the clock.
module set_release_sequencer
    import set_seq_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int REC_CYCLES  = REC_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RN,
    input  logic SET_REQ,
    output logic SETN_OUT,
    output logic CLK_EN,
    output logic BUSY,
    output logic DONE
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("set_release_sequencer: SYNC_STAGES out of range 2..4");
    end
    if (HOLD_CYCLES < HOLD_CYCLES_MIN || HOLD_CYCLES > HOLD_CYCLES_MAX) begin : g_bad_hold
        $error("set_release_sequencer: HOLD_CYCLES out of range 1..255");
    end
    if (REC_CYCLES < REC_CYCLES_MIN || REC_CYCLES > REC_CYCLES_MAX) begin : g_bad_rec
        $error("set_release_sequencer: REC_CYCLES out of range 1..255");
    end

    logic             w_rst_sync_n;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pend;
    logic             w_pend_nxt;
    logic             r_setn;
    logic             r_clk_en;
    logic             r_busy;
    logic             r_done;

    set_seq_rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .i_clk   (CLK),
        .i_rst_n (RN),
        .o_rst_n (w_rst_sync_n)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        if (SET_REQ && (r_state != ST_IDLE)) begin
            w_pend_nxt = 1'b1;
        end
        case (r_state)
            ST_RST_SYNC: begin
                // Loading the full hold length (not length-1) accounts for the
                // edge on which the released synchronizer is first observed.
                if (!w_rst_sync_n) begin
                    w_cnt_nxt = CNT_W'(HOLD_CYCLES);
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = cnt_load(REC_CYCLES);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_GATE: begin
                w_state_nxt = ST_ASSERT;
                w_cnt_nxt   = cnt_load(HOLD_CYCLES);
            end
            ST_ASSERT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = cnt_load(REC_CYCLES);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RECOVER: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_IDLE: begin
                if (SET_REQ || r_pend) begin
                    w_state_nxt = ST_GATE;
                    w_pend_nxt  = 1'b0;
                end
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_RST_SYNC;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register while still coming straight from flops.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state  <= ST_RST_SYNC;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_setn   <= 1'b0;
            r_clk_en <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pend   <= w_pend_nxt;
            r_setn   <= (w_state_nxt != ST_RST_SYNC) && (w_state_nxt != ST_ASSERT);
            r_clk_en <= (w_state_nxt == ST_IDLE);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= (w_state_nxt == ST_IDLE) && (r_state != ST_IDLE);
        end
    end

    assign SETN_OUT = r_setn;
    assign CLK_EN   = r_clk_en;
    assign BUSY     = r_busy;
    assign DONE     = r_done;

endmodule

// File: doc/set_release_sequencer.md
SET_RELEASE_SEQUENCER -- requirements
Module: set_release_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named CLK and RN.
REQ-002 Parameter SYNC_STAGES, default 2: number of RN deassertion synchronizer stages, legal range 2..4.
REQ-003 Parameter HOLD_CYCLES, default 4: number of CLK cycles SETN_OUT is held low per set sequence, legal range 1..255.
REQ-004 Parameter REC_CYCLES, default 2: number of cycles between SETN_OUT rising and CLK_EN rising (recovery gap), legal range 1..255.
REQ-005 CLK  input  1  sequencer clock; all state changes on its rising edge.
REQ-006 RN  input  1  asynchronous active-low reset.
REQ-007 SET_REQ  input  1  level request to preset the controlled negative-edge flop bank; sampled each CLK edge.
REQ-008 SETN_OUT  output  1  active-low set, driven to the SETN pins of the flop bank.
REQ-009 CLK_EN  output  1  clock-gate enable for the flop bank clock; 0 means the bank clock is stopped.
REQ-010 BUSY  output  1  high whenever the state is not IDLE.
REQ-011 DONE  output  1  one-cycle pulse on entry to IDLE after each completed sequence.

Function
REQ-012 States SHALL be RST_SYNC, GATE, ASSERT, RECOVER and IDLE; every output SHALL be a registered Moore decode of the state.
REQ-013 Outputs per state: RST_SYNC: SETN_OUT=0, CLK_EN=0. GATE: SETN_OUT=1, CLK_EN=0. ASSERT: SETN_OUT=0, CLK_EN=0. RECOVER: SETN_OUT=1, CLK_EN=0. IDLE: SETN_OUT=1, CLK_EN=1.
REQ-014 RST_SYNC SHALL be held while the synchronized reset is active, then for HOLD_CYCLES further cycles, then go to RECOVER.
REQ-015 In IDLE with SET_REQ=1: next state GATE for exactly 1 cycle, so the clock is stopped before SETN falls.
REQ-016 GATE SHALL go to ASSERT; ASSERT SHALL last exactly HOLD_CYCLES cycles and then go to RECOVER.
REQ-017 RECOVER SHALL last exactly REC_CYCLES cycles and then go to IDLE; DONE=1 in the first IDLE cycle only.
REQ-018 With default parameters, a SET_REQ sampled at edge 0 SHALL give: GATE at cycle 1, SETN_OUT low for cycles 2-5, recovery at cycles 6-7, and CLK_EN=1 with DONE=1 at cycle 8.
REQ-019 SETN_OUT and CLK_EN SHALL never both change on the same edge.
REQ-020 CLK_EN SHALL never be 1 while SETN_OUT=0.
REQ-021 A SET_REQ sampled high while BUSY SHALL set a single pending flag; a pending flag seen in IDLE SHALL start a new sequence on the next edge, exactly as SET_REQ=1 does, and clear the flag.
REQ-022 Multiple requests during one busy period SHALL collapse into one pending sequence.
REQ-023 The shared phase counter SHALL be 8 bits wide, load the state length minus 1 on state entry, and count down to 0 without wrapping.
REQ-024 In IDLE with SET_REQ held high continuously, back-to-back sequences SHALL run, each with a single DONE cycle and a single IDLE cycle between them.

Reset
REQ-025 When RN falls, the block SHALL asynchronously force state=RST_SYNC, SETN_OUT=0, CLK_EN=0, BUSY=1, DONE=0, pending=0 and counter=0.
REQ-026 RN rise SHALL be seen only through the SYNC_STAGES synchronizer; SETN_OUT SHALL stay low for at least SYNC_STAGES+HOLD_CYCLES edges after RN rises.
REQ-027 RN falling during any state, including mid-ASSERT or mid-RECOVER, SHALL abort the sequence with no DONE pulse.

Structure
REQ-028 A shared package set_seq_pkg SHALL hold the state enumeration, the counter width (8), and the parameter defaults and legal limits.
REQ-029 The reset deassertion synchronizer SHALL be a separate sub-module, set_seq_rst_sync (async assert, SYNC_STAGES-flop synchronous deassert).
REQ-030 Parameter legality SHALL be checked at elaboration, and an illegal value SHALL stop elaboration.

Verification
REQ-031 Reset release, default parameters: RN rises between edges 0 and 1 -> SETN_OUT=0 through edge 6, SETN_OUT=1 at edge 7, CLK_EN=1 at edge 9, DONE=1 at edge 9 only.
REQ-032 Single request: SET_REQ=1 for one cycle in IDLE -> exact REQ-018 waveform, including BUSY=1 for cycles 1-7.
REQ-033 Request during busy: SET_REQ pulses at cycles 3 and 5 -> exactly one extra sequence, with its GATE at cycle 9.
REQ-034 Reset mid-ASSERT: RN low at cycle 3 -> SETN_OUT=0 and CLK_EN=0 immediately, pending cleared, no DONE, and the full REQ-031 sequence after RN rises.
REQ-035 Parameter sweep HOLD_CYCLES=1 and REC_CYCLES=255: assertions for REQ-019 and REQ-020 hold every cycle, ASSERT lasts 1 cycle, and RECOVER lasts 255 cycles with no counter wrap.
